de0_nano_system_ext_sensor_trig: RTL and testbench
==================================================

// Module: de0_nano_system_ext_sensor_trig
// PURPOSE
//  Avalon-MM slave that drives the external sensor's trigger line. It is the output
//  counterpart of the sensor interrupt PIO. It generates a programmable burst of
//  pulses (high time, low time, count) on out_port, plus a sticky DONE flag and a
//  maskable level irq. It sits on the system Avalon fabric beside the sensor
//  interrupt PIO.
// PARAMETERS
//  CNT_WIDTH   16  width of HIGH_CNT, LOW_CNT, NPULSE and the internal counters
//  RESET_IDLE  0   reset value of DATA[0], the idle level of out_port
// PORTS
//  clk        in   1          system clock; all logic on rising edge
//  reset      in   1          synchronous, active-high reset
//  address    in   3          register select (word address)
//  chipselect in   1          slave select
//  write_n    in   1          active-low write strobe, qualified by chipselect
//  writedata  in   32         write data
//  readdata   out  32         registered read data
//  irq        out  1          level interrupt = STATUS.DONE & CONTROL.IRQ_EN
//  out_port   out  1          registered trigger line to the sensor
// BEHAVIOUR
//  Register map (reserved bits read 0):
//   0 DATA     R/W  [0] idle level; active level during a pulse = ~DATA[0]
//   1 CONTROL  W    [0] START, [1] STOP (write-1 strobes, read 0); R/W [2] IRQ_EN
//   2 HIGH_CNT R/W  pulse-high cycles; 0 behaves as 1
//   3 LOW_CNT  R/W  gap cycles; 0 behaves as 1
//   4 NPULSE   R/W  pulse count; 0 = run until STOP
//   5 STATUS   R    [0] BUSY, [1] DONE (sticky); any write to addr 5 clears DONE
//   6,7        read 0, writes ignored
//  Write = chipselect & ~write_n. readdata <= mux(address) every cycle, with 1-cycle latency.
//  Reset: DATA=RESET_IDLE, IRQ_EN=0, HIGH/LOW/NPULSE=0, DONE=0, FSM=IDLE,
//   out_port=RESET_IDLE, readdata=0, irq=0.
//  FSM states: IDLE, HIGH, LOW. BUSY = (state != IDLE).
//   IDLE: START -> HIGH, cnt=max(HIGH_CNT,1), left=NPULSE.
//   HIGH: cnt==1 -> if NPULSE!=0 and left==1, go IDLE and set DONE;
//         otherwise go LOW, cnt=max(LOW_CNT,1). Else cnt--.
//   LOW:  cnt==1 -> HIGH, cnt=max(HIGH_CNT,1), left-- (only if NPULSE was nonzero
//         at START). Else cnt--.
//  out_port is registered: it shows the active level in every cycle the FSM is in HIGH,
//   and the idle level otherwise. The first active cycle is the cycle after the START write.
//   A pulse is exactly max(HIGH_CNT,1) cycles; a gap is exactly max(LOW_CNT,1) cycles.
//  NPULSE is sampled only at START. HIGH_CNT and LOW_CNT are sampled at each phase load,
//   so writes during a burst apply from the next phase.
//  Writing DATA while busy changes both the idle and active levels on the next cycle.
//  STOP: from any state -> IDLE next cycle, out_port returns to idle, DONE is not set.
//  START while BUSY is ignored. STOP and START in one write: STOP wins, START is dropped.
//  DONE set and DONE clear in the same cycle: set wins.
//  left counter wraps never; NPULSE = 2^CNT_WIDTH-1 is the longest finite burst.
//  reset asserted mid-burst: everything returns to reset values on the next edge, with no
//   partial pulse extension.
// TESTING
//  1 reset, then read all addrs -> readdata 0 one cycle after each read; out_port=0, irq=0
//  2 HIGH=3, LOW=2, NPULSE=2, START -> out_port 1 for 3 cycles, 0 for 2, 1 for 3, then
//    idle; DONE=1, BUSY=0
//  3 IRQ_EN=1, repeat test 2 -> irq rises with DONE; write addr5 -> irq=0 next cycle
//  4 NPULSE=0, HIGH=0, LOW=0 -> continuous 1/0 toggle every cycle; STOP -> out_port 0,
//    DONE stays 0
//  5 DATA=1, HIGH=4, NPULSE=1 -> out_port idles at 1 and pulses 0 for 4 cycles;
//    START while busy -> no extra pulse
//  6 reset asserted on 2nd cycle of HIGH -> out_port=RESET_IDLE and BUSY=0 next cycle;
//    START+STOP in one write -> stays idle

Source files
------------

// File: rtl/de0_nano_system_ext_sensor_trig.sv
// Avalon-MM trigger generator for the external sensor.
// Produces a programmable burst of pulses on out_port (high time, gap time,
// pulse count) with a sticky DONE flag and a maskable level interrupt.
module de0_nano_system_ext_sensor_trig #(
    parameter int   CNT_WIDTH  = 16,
    parameter logic RESET_IDLE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t               state_r;
    logic                 data_r;
    logic                 irq_en_r;
    logic                 done_r;
    logic [CNT_WIDTH-1:0] high_cnt_r;
    logic [CNT_WIDTH-1:0] low_cnt_r;
    logic [CNT_WIDTH-1:0] npulse_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] left_r;
    logic                 finite_r;

    logic                 wr_s;
    logic                 start_s;
    logic                 stop_s;
    logic                 data_nx_s;
    logic                 irq_en_nx_s;
    logic                 done_set_s;
    logic                 done_clr_s;
    logic                 done_nx_s;
    logic [CNT_WIDTH-1:0] high_ld_s;
    logic [CNT_WIDTH-1:0] low_ld_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_s;

    // Decode bus strobes and compute next values of the flags shared by the FSM and register file.
    always_comb begin
        wr_s        = chipselect & ~write_n;
        stop_s      = wr_s && (address == 3'd1) && writedata[1];
        start_s     = wr_s && (address == 3'd1) && writedata[0] && !writedata[1];
        data_nx_s   = (wr_s && (address == 3'd0)) ? writedata[0] : data_r;
        irq_en_nx_s = (wr_s && (address == 3'd1)) ? writedata[2] : irq_en_r;
        // The last pulse of a finite burst is ending; a simultaneous STOP suppresses DONE.
        done_set_s  = (state_r == ST_HIGH) && (cnt_r == CNT_ONE) && finite_r &&
                      (left_r == CNT_ONE) && !stop_s;
        done_clr_s  = wr_s && (address == 3'd5);
        done_nx_s   = done_set_s ? 1'b1 : (done_clr_s ? 1'b0 : done_r);
        // A programmed count of zero behaves as one cycle.
        high_ld_s   = (high_cnt_r == CNT_ZERO) ? CNT_ONE : high_cnt_r;
        low_ld_s    = (low_cnt_r == CNT_ZERO) ? CNT_ONE : low_cnt_r;
        unused_s    = ^writedata[31:CNT_WIDTH];
    end

    // Read-data multiplexer; reserved bits and unmapped addresses return zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            3'd0:    rd_mux_s = {31'd0, data_r};
            3'd1:    rd_mux_s = {29'd0, irq_en_r, 2'b00};
            3'd2:    rd_mux_s = {{(32-CNT_WIDTH){1'b0}}, high_cnt_r};
            3'd3:    rd_mux_s = {{(32-CNT_WIDTH){1'b0}}, low_cnt_r};
            3'd4:    rd_mux_s = {{(32-CNT_WIDTH){1'b0}}, npulse_r};
            3'd5:    rd_mux_s = {30'd0, done_r, (state_r != ST_IDLE)};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Register file, registered read data and registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r     <= RESET_IDLE;
            irq_en_r   <= 1'b0;
            high_cnt_r <= CNT_ZERO;
            low_cnt_r  <= CNT_ZERO;
            npulse_r   <= CNT_ZERO;
            done_r     <= 1'b0;
            readdata   <= 32'd0;
            irq        <= 1'b0;
        end else begin
            data_r   <= data_nx_s;
            irq_en_r <= irq_en_nx_s;
            done_r   <= done_nx_s;
            readdata <= rd_mux_s;
            irq      <= done_nx_s & irq_en_nx_s;
            if (wr_s && (address == 3'd2)) begin
                high_cnt_r <= writedata[CNT_WIDTH-1:0];
            end
            if (wr_s && (address == 3'd3)) begin
                low_cnt_r <= writedata[CNT_WIDTH-1:0];
            end
            if (wr_s && (address == 3'd4)) begin
                npulse_r <= writedata[CNT_WIDTH-1:0];
            end
        end
    end

    // Pulse FSM; out_port is driven from the target state so it tracks HIGH exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            left_r   <= CNT_ZERO;
            finite_r <= 1'b0;
            out_port <= RESET_IDLE;
        end else if (stop_s) begin
            state_r  <= ST_IDLE;
            out_port <= data_nx_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r  <= ST_HIGH;
                        cnt_r    <= high_ld_s;
                        left_r   <= npulse_r;
                        finite_r <= (npulse_r != CNT_ZERO);
                        out_port <= ~data_nx_s;
                    end else begin
                        out_port <= data_nx_s;
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == CNT_ONE) begin
                        if (finite_r && (left_r == CNT_ONE)) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_LOW;
                            cnt_r   <= low_ld_s;
                        end
                        out_port <= data_nx_s;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                        out_port <= ~data_nx_s;
                    end
                end
                ST_LOW: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_HIGH;
                        cnt_r   <= high_ld_s;
                        if (finite_r) begin
                            left_r <= left_r - CNT_ONE;
                        end
                        out_port <= ~data_nx_s;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                        out_port <= data_nx_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    out_port <= data_nx_s;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_de0_nano_system_ext_sensor_trig.sv
// Scoreboard bench for the sensor trigger generator. A burst-level reference
// model (start cycle, phase lengths, end cycle) predicts out_port, irq and
// register reads; a monitor process compares every cycle and pops expected
// read data whenever a read result is presented.
module tb_de0_nano_system_ext_sensor_trig;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        out_port;

    de0_nano_system_ext_sensor_trig #(.CNT_WIDTH(16), .RESET_IDLE(1'b0)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-result presentation flag: a read issued in one cycle shows up after the next edge.
    logic rd_req = 1'b0;
    logic rd_valid = 1'b0;
    always @(posedge clk) rd_valid <= rd_req;

    logic [31:0] exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;

    // Reference model: register values plus a description of the current burst.
    bit data_m, irq_en_m, done_m;
    int h_m, l_m, n_m;
    bit run_act, run_fin;
    int run_start, run_end, run_h, run_l;

    function automatic bit busy_at(int e);
        return run_act && (!run_fin || e < run_end);
    endfunction

    function automatic bit done_at(int e);
        return done_m || (run_act && run_fin && e >= run_end);
    endfunction

    function automatic bit out_at(int e);
        if (!busy_at(e)) return data_m;
        if (((e - run_start) % (run_h + run_l)) < run_h) return ~data_m;
        return data_m;
    endfunction

    function automatic logic [31:0] reg_at(logic [2:0] a, int e);
        case (a)
            3'd0: return {31'd0, data_m};
            3'd1: return {29'd0, irq_en_m, 2'b00};
            3'd2: return h_m;
            3'd3: return l_m;
            3'd4: return n_m;
            3'd5: return {30'd0, done_at(e), busy_at(e)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic retire();
        if (run_act && run_fin && cyc >= run_end) begin
            done_m  = 1'b1;
            run_act = 1'b0;
        end
    endtask

    task automatic model_reset();
        data_m = 1'b0; irq_en_m = 1'b0; done_m = 1'b0;
        h_m = 0; l_m = 0; n_m = 0; run_act = 1'b0; run_fin = 1'b0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Monitor: compare continuous outputs each cycle and pop expected read data when presented.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_port", {31'd0, out_port}, {31'd0, out_at(cyc)});
            check("irq", {31'd0, irq}, {31'd0, irq_en_m & done_at(cyc)});
            if (rd_valid) begin
                if (exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
                else check("readdata", readdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bit busy0;
        retire();
        busy0 = busy_at(cyc);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        case (a)
            3'd0: data_m = d[0];
            3'd1: begin
                irq_en_m = d[2];
                if (d[1]) begin
                    run_act = 1'b0;
                end else if (d[0] && !busy0) begin
                    run_act   = 1'b1;
                    run_fin   = (n_m != 0);
                    run_start = cyc;
                    run_h     = (h_m == 0) ? 1 : h_m;
                    run_l     = (l_m == 0) ? 1 : l_m;
                    run_end   = cyc + n_m * run_h + (n_m - 1) * run_l;
                end
            end
            3'd2: h_m = d[15:0];
            3'd3: l_m = d[15:0];
            3'd4: n_m = d[15:0];
            3'd5: begin
                done_m = 1'b0;
                retire();
            end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a);
        retire();
        exp_q.push_back(reg_at(a, cyc));
        chipselect = 1'b1; write_n = 1'b1; address = a; rd_req = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic ctrl(input bit ie, input bit stp, input bit st);
        bus_write(3'd1, {29'd0, ie, stp, st});
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state: every address reads zero.
        for (int a = 0; a < 8; a++) bus_read(a[2:0]);

        // Two pulses, 3 high / 2 low, then DONE.
        bus_write(3'd2, 32'd3); bus_write(3'd3, 32'd2); bus_write(3'd4, 32'd2);
        ctrl(1'b0, 1'b0, 1'b1);
        bus_read(3'd5);
        idle(10);
        bus_read(3'd5);

        // Same burst with interrupt enabled, then clear DONE.
        bus_write(3'd5, 32'd0);
        ctrl(1'b1, 1'b0, 1'b1);
        idle(10);
        bus_read(3'd5);
        bus_write(3'd5, 32'd0);
        idle(2);

        // Free-running toggle until STOP.
        bus_write(3'd4, 32'd0); bus_write(3'd2, 32'd0); bus_write(3'd3, 32'd0);
        ctrl(1'b1, 1'b0, 1'b1);
        idle(9);
        ctrl(1'b1, 1'b1, 1'b0);
        bus_read(3'd5);
        idle(2);

        // Inverted idle level, single 4-cycle pulse, START while busy ignored.
        bus_write(3'd0, 32'd1); bus_write(3'd2, 32'd4); bus_write(3'd4, 32'd1);
        ctrl(1'b0, 1'b0, 1'b1);
        idle(1);
        ctrl(1'b0, 1'b0, 1'b1);
        idle(8);
        bus_read(3'd5);

        // Reset during the second cycle of HIGH, then START+STOP together.
        bus_write(3'd0, 32'd0); bus_write(3'd2, 32'd3);
        ctrl(1'b0, 1'b0, 1'b1);
        idle(1);
        do_reset();
        bus_read(3'd5);
        bus_read(3'd0);
        bus_write(3'd2, 32'd2);
        ctrl(1'b0, 1'b1, 1'b1);
        idle(3);
        bus_read(3'd5);

        // Randomized bursts against the model.
        for (int it = 0; it < 30; it++) begin
            retire();
            if (busy_at(cyc)) ctrl(irq_en_m, 1'b1, 1'b0);
            bus_write(3'd0, {31'd0, 1'($urandom_range(0, 1))});
            bus_write(3'd2, $urandom_range(0, 4));
            bus_write(3'd3, $urandom_range(0, 4));
            bus_write(3'd4, $urandom_range(0, 3));
            ctrl(1'($urandom_range(0, 1)), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) ctrl(irq_en_m, 1'b0, 1'b1);
            idle($urandom_range(0, 25));
            bus_read(3'($urandom_range(0, 7)));
            bus_read(3'd5);
            if ($urandom_range(0, 2) == 0) bus_write(3'd5, 32'd0);
            if ($urandom_range(0, 4) == 0) bus_write(3'd0, {31'd0, ~data_m});
            idle($urandom_range(0, 5));
        end

        idle(3);
        chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL rd_queue_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
